// File: rtl/apb_regs_slave.sv
// APB3 completer register block for the aligner core: CTRL, STATUS, IRQEN, IRQ.
// Define APB_SLVERR_EN to drive pslverr; otherwise pslverr is tied low.
module apb_regs_slave #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  preset,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    input  logic [3:0]            rx_lvl,
    input  logic [3:0]            tx_lvl,
    input  logic [7:0]            cnt_drop,
    input  logic [4:0]            evt,
    output logic [2:0]            ctrl_size,
    output logic [1:0]            ctrl_offset,
    output logic                  ctrl_clr,
    output logic                  irq
);

    localparam logic [ADDR_WIDTH-1:0] A_CTRL  = ADDR_WIDTH'(16'h0000);
    localparam logic [ADDR_WIDTH-1:0] A_STAT  = ADDR_WIDTH'(16'h000C);
    localparam logic [ADDR_WIDTH-1:0] A_IRQEN = ADDR_WIDTH'(16'h00F0);
    localparam logic [ADDR_WIDTH-1:0] A_IRQ   = ADDR_WIDTH'(16'h00F4);

    logic [3:0]            cnt;
    logic                  access;
    logic                  hit_ctrl;
    logic                  hit_stat;
    logic                  hit_irqen;
    logic                  hit_irq;
    logic                  wr_ok;
    logic                  err;
    logic                  commit;
    logic [DATA_WIDTH-1:0] rdata;
    logic [2:0]            size_q;
    logic [1:0]            offset_q;
    logic [4:0]            irqen_q;
    logic [4:0]            irq_q;
    logic [4:0]            irq_clr;
    logic                  unused_ok;

    assign access = psel & penable;
    assign pready = access & ~preset & (cnt == 4'(WAIT_STATES));

    // Counter only advances during access phase; anything else restarts it.
    always_ff @(posedge clk) begin
        if (preset || !access || pready) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    assign hit_ctrl  = (paddr == A_CTRL);
    assign hit_stat  = (paddr == A_STAT);
    assign hit_irqen = (paddr == A_IRQEN);
    assign hit_irq   = (paddr == A_IRQ);

    // SIZE==0 is not a legal geometry, so such a CTRL write is refused.
    assign wr_ok  = hit_ctrl ? (pwdata[2:0] != 3'd0) : (hit_irqen | hit_irq);
    assign err    = pwrite ? ~wr_ok
                           : ~(hit_ctrl | hit_stat | hit_irqen | hit_irq);
    assign commit = pready & pwrite & wr_ok;

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            hit_ctrl: begin
                rdata[2:0] = size_q;
                rdata[9:8] = offset_q;
            end
            hit_stat: begin
                rdata[3:0]   = rx_lvl;
                rdata[11:8]  = tx_lvl;
                rdata[23:16] = cnt_drop;
            end
            hit_irqen: rdata[4:0] = irqen_q;
            hit_irq:   rdata[4:0] = irq_q;
            default:   rdata = '0;
        endcase
    end

    assign prdata   = (pready & ~pwrite) ? rdata : '0;
    assign ctrl_clr = commit & hit_ctrl & pwdata[16];
    assign irq_clr  = (commit & hit_irq) ? pwdata[4:0] : 5'd0;

    always_ff @(posedge clk) begin
        if (preset) begin
            size_q   <= 3'd1;
            offset_q <= 2'd0;
            irqen_q  <= 5'd0;
            irq_q    <= 5'd0;
            irq      <= 1'b0;
        end else begin
            if (commit && hit_ctrl) begin
                size_q   <= pwdata[2:0];
                offset_q <= pwdata[9:8];
            end
            if (commit && hit_irqen) begin
                irqen_q <= pwdata[4:0];
            end
            // A new event outranks a simultaneous clear.
            irq_q <= (irq_q & ~irq_clr) | evt;
            irq   <= |(irq_q & irqen_q);
        end
    end

    assign ctrl_size   = size_q;
    assign ctrl_offset = offset_q;

`ifdef APB_SLVERR_EN
    assign pslverr   = pready & err;
    assign unused_ok = ^pwdata;
`else
    assign pslverr   = 1'b0;
    assign unused_ok = ^{pwdata, err};
`endif

endmodule

// File: tb/tb_apb_regs_slave.sv
// Scoreboard bench for apb_regs_slave: expected read data and error are
// queued when a transfer is issued and compared when pready is seen.
module tb_apb_regs_slave;

    localparam int WS = 1;

`ifdef APB_SLVERR_EN
    localparam logic E = 1'b1;
`else
    localparam logic E = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        preset = 1'b1;
    logic [15:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [3:0]  rx_lvl = '0;
    logic [3:0]  tx_lvl = '0;
    logic [7:0]  cnt_drop = '0;
    logic [4:0]  evt = '0;
    logic [2:0]  ctrl_size;
    logic [1:0]  ctrl_offset;
    logic        ctrl_clr;
    logic        irq;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   clr_cnt = 0;
    int   acc = 0;

    apb_regs_slave #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .WAIT_STATES(WS)
    ) dut (
        .clk        (clk),
        .preset     (preset),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .psel       (psel),
        .penable    (penable),
        .pwdata     (pwdata),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr),
        .rx_lvl     (rx_lvl),
        .tx_lvl     (tx_lvl),
        .cnt_drop   (cnt_drop),
        .evt        (evt),
        .ctrl_size  (ctrl_size),
        .ctrl_offset(ctrl_offset),
        .ctrl_clr   (ctrl_clr),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Monitor: sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (ctrl_clr) clr_cnt++;
        if (pready) begin
            acc++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("prdata", prdata, e.rdata);
                chk("pslverr", {31'd0, pslverr}, {31'd0, e.err});
                chk("wait_cycles", acc, WS + 1);
            end
            acc = 0;
        end else begin
            if (psel && penable) acc++;
            else acc = 0;
            chk("idle_prdata", prdata, 32'd0);
            chk("idle_pslverr", {31'd0, pslverr}, 32'd0);
        end
    end

    task automatic xfer(input logic [15:0] a, input logic w,
                        input logic [31:0] d, input logic [31:0] er,
                        input logic ee, input logic [4:0] ev);
        int n;
        sb.push_back('{er, ee});
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0;
        paddr = a; pwrite = w; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pready && n < 20);
        if (!pready) chk("pready_timeout", 32'd0, 32'd1);
        evt = ev;
        @(posedge clk); #1;
        evt = 5'd0;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] er,
                      input logic ee);
        xfer(a, 1'b0, 32'd0, er, ee, 5'd0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d,
                      input logic ee);
        xfer(a, 1'b1, d, 32'd0, ee, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pready", {31'd0, pready}, 32'd0);
        chk("rst_size", {29'd0, ctrl_size}, 32'd1);
        chk("rst_offset", {30'd0, ctrl_offset}, 32'd0);
        chk("rst_clr", {31'd0, ctrl_clr}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        preset = 1'b0;

        rd(16'h0000, 32'h0000_0001, 1'b0);

        wr(16'h0000, 32'h0001_0203, 1'b0);
        chk("size_3", {29'd0, ctrl_size}, 32'd3);
        chk("offset_2", {30'd0, ctrl_offset}, 32'd2);
        chk("clr_once", clr_cnt, 32'd1);
        rd(16'h0000, 32'h0000_0203, 1'b0);

        wr(16'h0004, 32'hFFFF_FFFF, E);
        rd(16'h0000, 32'h0000_0203, 1'b0);
        wr(16'h0000, 32'h0001_0000, E);
        chk("size_kept", {29'd0, ctrl_size}, 32'd3);
        chk("no_clr_on_err", clr_cnt, 32'd1);
        rd(16'h0000, 32'h0000_0203, 1'b0);
        rd(16'h0004, 32'h0000_0000, E);

        wr(16'h00F0, 32'hFFFF_FFFF, 1'b0);
        rd(16'h00F0, 32'h0000_001F, 1'b0);
        rd(16'h00F4, 32'h0000_0000, 1'b0);
        @(posedge clk); #1;
        evt = 5'b00100;
        @(posedge clk); #1;
        evt = 5'd0;
        @(negedge clk);
        @(negedge clk);
        chk("irq_set", {31'd0, irq}, 32'd1);
        rd(16'h00F4, 32'h0000_0004, 1'b0);
        wr(16'h00F4, 32'h0000_0004, 1'b0);
        repeat (2) @(negedge clk);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        rd(16'h00F4, 32'h0000_0000, 1'b0);

        xfer(16'h00F4, 1'b1, 32'h0000_0004, 32'd0, 1'b0, 5'b00100);
        repeat (2) @(negedge clk);
        chk("irq_set_wins", {31'd0, irq}, 32'd1);
        rd(16'h00F4, 32'h0000_0004, 1'b0);
        xfer(16'h00F4, 1'b1, 32'h0000_0001, 32'd0, 1'b0, 5'b00010);
        rd(16'h00F4, 32'h0000_0006, 1'b0);
        wr(16'h00F0, 32'h0000_0001, 1'b0);
        repeat (2) @(negedge clk);
        chk("irq_masked", {31'd0, irq}, 32'd0);

        rx_lvl = 4'h5; tx_lvl = 4'hA; cnt_drop = 8'h3C;
        rd(16'h000C, 32'h003C_0A05, 1'b0);
        wr(16'h000C, 32'h1234_5678, E);
        rd(16'h000C, 32'h003C_0A05, 1'b0);
        rd(16'h0000, 32'h0000_0203, 1'b0);

        wr(16'h00F0, 32'h0000_001F, 1'b0);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0;
        paddr = 16'h00F0; pwrite = 1'b1; pwdata = 32'h0000_0003;
        @(posedge clk); #1;
        penable = 1'b1;
        preset = 1'b1;
        @(negedge clk);
        chk("rst_abort_pready", {31'd0, pready}, 32'd0);
        @(posedge clk); #1;
        preset = 1'b0;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("rst_abort_size", {29'd0, ctrl_size}, 32'd1);
        rd(16'h00F0, 32'h0000_0000, 1'b0);
        rd(16'h00F4, 32'h0000_0000, 1'b0);
        rd(16'h0000, 32'h0000_0001, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
